// File: rtl/timeclock_pkg.sv
// Shared encodings, field limits and blink masks for the TimeClock set controller.
package timeclock_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_e;

    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] SEC_MAX  = 6'd59;

    localparam logic [5:0] MASK_HOUR = 6'b110000;
    localparam logic [5:0] MASK_MIN  = 6'b001100;
    localparam logic [5:0] MASK_SEC  = 6'b000011;

    // Step a field by one with wrap-around inside 0..max_val.
    function automatic logic [5:0] wrap_step(input logic [5:0] val,
                                             input logic [5:0] max_val,
                                             input logic       up);
        if (up)
            return (val >= max_val) ? 6'd0 : val + 6'd1;
        else
            return (val == 6'd0 || val > max_val) ? max_val : val - 6'd1;
    endfunction

    function automatic logic [5:0] clamp(input logic [5:0] val, input logic [5:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge press detector; previous value resets high so a button held
// through reset release is not seen as a press.
module btn_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_press
);

    logic prev_q;
    logic prev_d;

    always_comb prev_d = i_btn;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) prev_q <= 1'b1;
        else         prev_q <= prev_d;
    end

    assign o_press = i_btn & ~prev_q;

endmodule

// File: rtl/timeclock_set_ctrl.sv
// RUN / SET sequencer for the TimeClock counter: shadow editing, load strobe,
// inactivity timeout and per-field blink masks.
module timeclock_set_ctrl
    import timeclock_pkg::*;
#(
    parameter int unsigned BLINK_HALF     = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_mode,
    input  logic       i_btn_sel,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic [5:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    output logic       o_run_en,
    output logic       o_load,
    output logic [5:0] o_load_hour,
    output logic [5:0] o_load_min,
    output logic [5:0] o_load_sec,
    output logic [5:0] o_disp_hour,
    output logic [5:0] o_disp_min,
    output logic [5:0] o_disp_sec,
    output logic [5:0] o_blink_mask,
    output logic [1:0] o_state
);

    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

    logic press_mode, press_sel, press_up, press_down, any_press;

    btn_edge_detect u_mode (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_mode), .o_press(press_mode));
    btn_edge_detect u_sel  (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_sel),  .o_press(press_sel));
    btn_edge_detect u_up   (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_up),   .o_press(press_up));
    btn_edge_detect u_down (.i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_down), .o_press(press_down));

    assign any_press = press_mode | press_sel | press_up | press_down;

    state_e             state_q, state_d;
    logic [5:0]         hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic               load_q, load_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               phase_q, phase_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        load_d  = 1'b0;
        blink_d = '0;
        phase_d = 1'b0;
        tmo_d   = '0;

        if (state_q == ST_RUN) begin
            if (press_mode) begin
                hour_d  = clamp(i_hour, HOUR_MAX);
                min_d   = clamp(i_min, MIN_MAX);
                sec_d   = clamp(i_sec, SEC_MAX);
                state_d = ST_SET_HOUR;
            end
        end else if (any_press) begin
            // Any press leaves blink and idle timers at zero so the field shows at once.
            if (press_mode) begin
                load_d  = 1'b1;
                state_d = ST_RUN;
            end else if (press_sel) begin
                case (state_q)
                    ST_SET_HOUR: state_d = ST_SET_MIN;
                    ST_SET_MIN:  state_d = ST_SET_SEC;
                    default:     state_d = ST_SET_HOUR;
                endcase
            end else begin
                case (state_q)
                    ST_SET_HOUR: hour_d = wrap_step(hour_q, HOUR_MAX, press_up);
                    ST_SET_MIN:  min_d  = wrap_step(min_q, MIN_MAX, press_up);
                    default:     sec_d  = wrap_step(sec_q, SEC_MAX, press_up);
                endcase
            end
        end else if (tmo_q == TMO_LAST) begin
            state_d = ST_RUN;
        end else begin
            tmo_d   = tmo_q + TMO_W'(1);
            blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + BLINK_W'(1);
            phase_d = (blink_q == BLINK_LAST) ? ~phase_q : phase_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_RUN;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            load_q  <= 1'b0;
            blink_q <= '0;
            phase_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            load_q  <= load_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        o_blink_mask = '0;
        if (phase_q) begin
            case (state_q)
                ST_SET_HOUR: o_blink_mask = MASK_HOUR;
                ST_SET_MIN:  o_blink_mask = MASK_MIN;
                ST_SET_SEC:  o_blink_mask = MASK_SEC;
                default:     o_blink_mask = '0;
            endcase
        end
    end

    assign o_run_en    = (state_q == ST_RUN);
    assign o_load      = load_q;
    assign o_load_hour = hour_q;
    assign o_load_min  = min_q;
    assign o_load_sec  = sec_q;
    assign o_disp_hour = (state_q == ST_RUN) ? i_hour : hour_q;
    assign o_disp_min  = (state_q == ST_RUN) ? i_min  : min_q;
    assign o_disp_sec  = (state_q == ST_RUN) ? i_sec  : sec_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_timeclock_set_ctrl.sv
// Bench for timeclock_set_ctrl: per-cycle comparison against a behavioural model
// plus hand-computed checkpoints.
module tb_timeclock_set_ctrl;

    localparam int BH = 4;
    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_mode = 1'b0, b_sel = 1'b0, b_up = 1'b0, b_down = 1'b0;
    logic [5:0] hour_in = 6'd23, min_in = 6'd59, sec_in = 6'd58;

    logic       run_en, load;
    logic [5:0] load_hour, load_min, load_sec, disp_hour, disp_min, disp_sec, mask;
    logic [1:0] state;

    timeclock_set_ctrl #(.BLINK_HALF(BH), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_btn_mode(b_mode), .i_btn_sel(b_sel), .i_btn_up(b_up), .i_btn_down(b_down),
        .i_hour(hour_in), .i_min(min_in), .i_sec(sec_in),
        .o_run_en(run_en), .o_load(load),
        .o_load_hour(load_hour), .o_load_min(load_min), .o_load_sec(load_sec),
        .o_disp_hour(disp_hour), .o_disp_min(disp_min), .o_disp_sec(disp_sec),
        .o_blink_mask(mask), .o_state(state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_loads = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 = RUN, 1..3 = editing hour/min/sec; m_idle counts cycles since the last press.
    int m_state = 0, m_h = 0, m_m = 0, m_s = 0, m_idle = 0;
    bit m_load = 0;
    bit p_mode = 1, p_sel = 1, p_up = 1, p_down = 1;
    bit pm, ps, pu, pd;
    int step;

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_h = 0; m_m = 0; m_s = 0; m_idle = 0; m_load = 0;
            p_mode = 1; p_sel = 1; p_up = 1; p_down = 1;
        end else begin
            pm = b_mode && !p_mode;
            ps = b_sel  && !p_sel;
            pu = b_up   && !p_up;
            pd = b_down && !p_down;
            p_mode = b_mode; p_sel = b_sel; p_up = b_up; p_down = b_down;
            m_load = 0;
            if (m_state == 0) begin
                if (pm) begin
                    m_h = clampi(int'(hour_in), 23);
                    m_m = clampi(int'(min_in), 59);
                    m_s = clampi(int'(sec_in), 59);
                    m_state = 1;
                    m_idle = 0;
                end
            end else if (pm || ps || pu || pd) begin
                m_idle = 0;
                if (pm) begin
                    m_load = 1;
                    m_state = 0;
                end else if (ps) begin
                    m_state = (m_state == 3) ? 1 : m_state + 1;
                end else begin
                    step = pu ? 1 : -1;
                    if (m_state == 1)      m_h = (m_h + step + 24) % 24;
                    else if (m_state == 2) m_m = (m_m + step + 60) % 60;
                    else                   m_s = (m_s + step + 60) % 60;
                end
            end else begin
                m_idle++;
                if (m_idle == TO) m_state = 0;
            end
        end
    end

    int exp_mask;
    always @(negedge clk) begin
        if (m_state != 0 && ((m_idle / BH) % 2) == 1)
            exp_mask = (m_state == 1) ? 48 : (m_state == 2) ? 12 : 3;
        else
            exp_mask = 0;
        check("state", state, m_state);
        check("run_en", run_en, m_state == 0);
        check("load", load, m_load);
        check("load_hour", load_hour, m_h);
        check("load_min", load_min, m_m);
        check("load_sec", load_sec, m_s);
        check("disp_hour", disp_hour, (m_state == 0) ? int'(hour_in) : m_h);
        check("disp_min", disp_min, (m_state == 0) ? int'(min_in) : m_m);
        check("disp_sec", disp_sec, (m_state == 0) ? int'(sec_in) : m_s);
        check("blink_mask", mask, exp_mask);
        if (load === 1'b1) n_loads++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] b);
        {b_mode, b_sel, b_up, b_down} = b;
        tick(1);
        {b_mode, b_sel, b_up, b_down} = 4'b0000;
        tick(1);
    endtask

    localparam logic [3:0] P_MODE = 4'b1000, P_SEL = 4'b0100, P_UP = 4'b0010, P_DOWN = 4'b0001;

    int loads_before;

    initial begin
        // Reset with mode and up held through release.
        b_mode = 1; b_up = 1;
        tick(3);
        check("rst_state", state, 0);
        check("rst_run_en", run_en, 1);
        check("rst_load", load, 0);
        check("rst_mask", mask, 0);
        check("rst_shadow_hour", load_hour, 0);
        rst = 0;
        tick(3);
        check("held_mode_no_entry", state, 0);
        b_mode = 0;
        tick(1);
        // Enter SET with up still held: no increment until it is released and pressed again.
        b_mode = 1; tick(1); b_mode = 0; tick(1);
        check("enter_state", state, 1);
        check("enter_run_en", run_en, 0);
        check("enter_disp_hour", disp_hour, 23);
        tick(2);
        check("held_up_no_change", disp_hour, 23);
        b_up = 0; tick(1);
        pulse(P_UP);
        check("hour_up_wrap", disp_hour, 0);
        pulse(P_DOWN);
        check("hour_down_wrap", disp_hour, 23);
        hour_in = 6'd10; tick(1);
        check("set_shows_shadow", disp_hour, 23);

        pulse(P_SEL);
        check("sel_min", state, 2);
        check("min_shadow", disp_min, 59);
        pulse(P_UP);
        check("min_up_wrap", disp_min, 0);
        pulse(P_SEL);
        check("sel_sec", state, 3);
        pulse(P_SEL);
        check("sel_hour", state, 1);

        // Edit shadow to 5:07:30 and exit.
        repeat (6) pulse(P_UP);
        pulse(P_SEL);
        repeat (7) pulse(P_UP);
        pulse(P_SEL);
        repeat (28) pulse(P_DOWN);
        check("edit_hour", disp_hour, 5);
        check("edit_min", disp_min, 7);
        check("edit_sec", disp_sec, 30);
        b_mode = 1; tick(1);
        check("exit_load", load, 1);
        check("exit_load_hour", load_hour, 5);
        check("exit_load_min", load_min, 7);
        check("exit_load_sec", load_sec, 30);
        check("exit_run_en", run_en, 1);
        check("exit_state", state, 0);
        b_mode = 0; tick(1);
        check("load_one_cycle", load, 0);

        // Out-of-range capture clamps; then inactivity timeout.
        hour_in = 6'd30; min_in = 6'd61; sec_in = 6'd60;
        loads_before = n_loads;
        pulse(P_MODE);
        check("clamp_hour", disp_hour, 23);
        check("clamp_min", disp_min, 59);
        check("clamp_sec", disp_sec, 59);
        tick(47);
        check("tmo_48_still_set", state, 1);
        tick(1);
        check("tmo_49_still_set", state, 1);
        tick(1);
        check("tmo_exit_state", state, 0);
        check("tmo_exit_run_en", run_en, 1);
        pulse(P_MODE);
        tick(38);
        pulse(P_UP);
        tick(48);
        check("tmo_restart_still_set", state, 1);
        tick(1);
        check("tmo_restart_exit", state, 0);
        check("tmo_no_load", n_loads, loads_before);

        // Blink pattern in SET_MIN, press blanking, and mode+up collision.
        hour_in = 6'd12; min_in = 6'd20; sec_in = 6'd45;
        pulse(P_MODE);
        pulse(P_SEL);
        tick(2);
        check("blink_off_3", mask, 6'b000000);
        tick(1);
        check("blink_on_4", mask, 6'b001100);
        tick(3);
        check("blink_on_7", mask, 6'b001100);
        tick(1);
        check("blink_off_8", mask, 6'b000000);
        tick(4);
        check("blink_on_12", mask, 6'b001100);
        b_up = 1; tick(1);
        check("press_blanks", mask, 6'b000000);
        check("press_min_inc", disp_min, 21);
        b_up = 0; tick(1);
        b_mode = 1; b_up = 1; tick(1);
        check("collide_load", load, 1);
        check("collide_min", load_min, 21);
        check("collide_state", state, 0);
        b_mode = 0; b_up = 0; tick(2);
        check("collide_min_after", load_min, 21);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
